// File: rtl/mips_bus_ram_model.sv
// Word-addressed RAM slave for the mips_cpu_bus: programmable wait states, byte lanes, sticky error flag.
// Accepts on the edge where waitrequest is low; read data registered on that edge; debug port is combinational.
module mips_bus_ram_model #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          BYTE_SWAP   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  input  logic [31:0] dbg_index,
  output logic [31:0] dbg_data
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          HasWait  = (WAIT_CYCLES != 0);
  localparam logic [3:0]  WaitMax  = 4'(WAIT_CYCLES);
  localparam logic [29:0] BaseWord = BASE_ADDR[31:2];
  localparam logic [31:0] Depth    = 32'(DEPTH_WORDS);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] readdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        req;
  logic        accept;
  logic        both;
  logic        addr_zero;
  logic        aligned;
  logic        in_range;
  logic        do_write;
  logic [29:0] word_idx;
  logic [31:0] rd_word;
  logic [31:0] rd_lanes;

  // Bus lane n lives in stored lane 3-n when the image is big-endian.
  function automatic int unsigned lane_map(input int unsigned n);
    return BYTE_SWAP ? (3 - n) : n;
  endfunction

  assign req       = read | write;
  assign both      = read & write;
  assign addr_zero = (address == 32'h0);
  assign aligned   = (address[1:0] == 2'b00);
  assign word_idx  = address[31:2] - BaseWord;
  assign in_range  = ({2'b00, word_idx} < Depth);

  // cnt_q never exceeds WaitMax, so inequality is the "still waiting" test.
  assign waitrequest = reset | (req & HasWait & (cnt_q != WaitMax));
  assign accept      = ~reset & req & ~waitrequest;
  assign do_write    = accept & write & ~read & ~addr_zero & aligned & in_range;

  always_comb begin
    rd_word  = mem_q[word_idx[AW-1:0]];
    rd_lanes = '0;
    for (int n = 0; n < 4; n++) begin
      if (byteenable[n]) rd_lanes[8*n +: 8] = rd_word[8*lane_map(n) +: 8];
    end
  end

  // Storage has no reset: contents survive bus resets.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int n = 0; n < 4; n++) begin
        if (byteenable[n]) mem_q[word_idx[AW-1:0]][8*lane_map(n) +: 8] <= writedata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'h0;
      err_q      <= 1'b0;
    end else if (accept) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      if (both) begin
        err_q <= 1'b1;
      end else if (addr_zero) begin
        if (read) readdata_q <= 32'h0;
      end else if (!aligned) begin
        err_q <= 1'b1;
      end else if (!in_range) begin
        err_q <= 1'b1;
        if (read) readdata_q <= 32'h0;
      end else if (read) begin
        readdata_q <= rd_lanes;
      end
    end else if (req) begin
      state_q <= S_WAIT;
      cnt_q   <= cnt_q + 4'd1;
    end else if (state_q == S_WAIT) begin
      // Master withdrew its request before it was accepted.
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b1;
    end
  end

  assign readdata = readdata_q;
  assign err      = err_q;
  assign dbg_data = (dbg_index < Depth) ? mem_q[dbg_index[AW-1:0]] : 32'h0;

endmodule

// File: tb/tb_mips_bus_ram_model.sv
// Directed bench: zero-wait instance (sel=0) and three-wait instance (sel=1) sharing one bus driver.
module tb_mips_bus_ram_model;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic [31:0] dbg_index = 32'h0;

  logic        wait0, wait3, err0, err3;
  logic [31:0] rdata0, rdata3, dbg0, dbg3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_ram_model #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .read(rd & ~sel), .write(wr & ~sel),
    .writedata(wdata), .byteenable(be), .waitrequest(wait0), .readdata(rdata0),
    .err(err0), .dbg_index(dbg_index), .dbg_data(dbg0)
  );

  mips_bus_ram_model #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .address(address), .read(rd & sel), .write(wr & sel),
    .writedata(wdata), .byteenable(be), .waitrequest(wait3), .readdata(rdata3),
    .err(err3), .dbg_index(dbg_index), .dbg_data(dbg3)
  );

  logic        wreq;
  assign wreq = sel ? wait3 : wait0;

  // Drives one request, holds it through waitrequest, releases it just after the accept edge.
  task automatic bus_op(input logic s, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    int n;
    @(posedge clk); #1;
    sel = s; rd = r; wr = w; address = a; wdata = d; be = b;
    n = 0;
    @(negedge clk);
    while (wreq && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (wreq) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout addr=%h waitrequest still high after %0d cycles", a, n);
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL reset_wait0 got=%b exp=1", wait0); end
    checks++; if (wait3 !== 1'b1) begin errors++; $display("FAIL reset_wait3 got=%b exp=1", wait3); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL post_reset_wait0 got=%b exp=0", wait0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got=%b exp=0", err0); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL reset_err3 got=%b exp=0", err3); end
  endtask

  task automatic test_basic();
    bus_op(0, 0, 1, 32'hBFC00100, 32'h11223344, 4'hF);
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL write_keeps_rdata got=%h exp=0", rdata0); end
    bus_op(0, 1, 0, 32'hBFC00100, 32'h0, 4'hF);
    checks++; if (rdata0 !== 32'h11223344) begin errors++; $display("FAIL basic_read got=%h exp=11223344", rdata0); end
    dbg_index = 32'd64;
    #1;
    checks++; if (dbg0 !== 32'h44332211) begin errors++; $display("FAIL basic_dbg got=%h exp=44332211", dbg0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err0); end
  endtask

  task automatic test_byte_lanes();
    bus_op(0, 0, 1, 32'hBFC00200, 32'h0, 4'hF);
    bus_op(0, 0, 1, 32'hBFC00200, 32'hAABBCCDD, 4'b0101);
    bus_op(0, 1, 0, 32'hBFC00200, 32'h0, 4'hF);
    checks++; if (rdata0 !== 32'h00BB00DD) begin errors++; $display("FAIL lanes_read_full got=%h exp=00BB00DD", rdata0); end
    bus_op(0, 1, 0, 32'hBFC00200, 32'h0, 4'b0011);
    checks++; if (rdata0 !== 32'h000000DD) begin errors++; $display("FAIL lanes_read_low got=%h exp=000000DD", rdata0); end
    bus_op(0, 0, 1, 32'hBFC00200, 32'hAABBCCDD, 4'b0010);
    bus_op(0, 1, 0, 32'hBFC00200, 32'h0, 4'b0011);
    checks++; if (rdata0 !== 32'h0000CCDD) begin errors++; $display("FAIL lanes_read_low2 got=%h exp=0000CCDD", rdata0); end
    dbg_index = 32'd128;
    #1;
    checks++; if (dbg0 !== 32'hDDCCBB00) begin errors++; $display("FAIL lanes_dbg got=%h exp=DDCCBB00", dbg0); end
    bus_op(0, 1, 0, 32'hBFC00200, 32'h0, 4'h0);
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL lanes_be0 got=%h exp=0", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL lanes_err got=%b exp=0", err0); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    sel = 0; wr = 1; rd = 0; address = 32'hBFC00004; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk); #1;
    wr = 0; rd = 1;
    @(posedge clk); #1;
    rd = 0;
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL raw_read got=%h exp=CAFEF00D", rdata0); end
    dbg_index = 32'd1;
    #1;
    checks++; if (dbg0 !== 32'h0DF0FECA) begin errors++; $display("FAIL raw_dbg got=%h exp=0DF0FECA", dbg0); end
  endtask

  task automatic test_errors();
    bus_op(0, 0, 1, 32'hBFC00000, 32'h12345678, 4'hF);
    bus_op(0, 1, 0, 32'h00000000, 32'h0, 4'hF);
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL addr0_rdata got=%h exp=0", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL addr0_err got=%b exp=0", err0); end
    bus_op(0, 1, 0, 32'hBFC00004, 32'h0, 4'hF);
    bus_op(0, 1, 0, 32'hBFC01000, 32'h0, 4'hF);
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", rdata0); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", err0); end
    bus_op(0, 1, 0, 32'hBFC00004, 32'h0, 4'hF);
    bus_op(0, 0, 1, 32'hBFC00002, 32'hFFFFFFFF, 4'hF);
    bus_op(0, 1, 0, 32'hBFC00006, 32'h0, 4'hF);
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_rdata got=%h exp=CAFEF00D", rdata0); end
    dbg_index = 32'd0;
    #1;
    checks++; if (dbg0 !== 32'h78563412) begin errors++; $display("FAIL misalign_mem got=%h exp=78563412", dbg0); end
    dbg_index = 32'd1024;
    #1;
    checks++; if (dbg0 !== 32'h0) begin errors++; $display("FAIL dbg_oor got=%h exp=0", dbg0); end
  endtask

  task automatic test_rw_both();
    bus_op(0, 1, 0, 32'hBFC00004, 32'h0, 4'hF);
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL mem_kept_over_reset got=%h exp=CAFEF00D", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", err0); end
    bus_op(0, 1, 1, 32'hBFC00004, 32'h0, 4'hF);
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL rw_both_err got=%b exp=1", err0); end
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_both_rdata got=%h exp=CAFEF00D", rdata0); end
    dbg_index = 32'd1;
    #1;
    checks++; if (dbg0 !== 32'h0DF0FECA) begin errors++; $display("FAIL rw_both_mem got=%h exp=0DF0FECA", dbg0); end
  endtask

  task automatic test_wait_states();
    int highs;
    bus_op(1, 0, 1, 32'hBFC00010, 32'h01020304, 4'hF);
    @(posedge clk); #1;
    sel = 1; rd = 1; wr = 0; address = 32'hBFC00010; be = 4'hF;
    highs = 0;
    @(negedge clk);
    while (wait3 && highs < 20) begin
      highs++;
      @(negedge clk);
    end
    checks++; if (highs != 3) begin errors++; $display("FAIL wait_cycles got=%0d exp=3", highs); end
    @(posedge clk); #1;
    rd = 0;
    checks++; if (rdata3 !== 32'h01020304) begin errors++; $display("FAIL wait_read got=%h exp=01020304", rdata3); end
  endtask

  task automatic test_abort();
    int highs;
    @(posedge clk); #1;
    sel = 1; rd = 1; wr = 0; address = 32'hBFC00010; be = 4'hF;
    @(negedge clk);
    checks++; if (wait3 !== 1'b1) begin errors++; $display("FAIL abort_wait got=%b exp=1", wait3); end
    @(posedge clk); #1;
    rd = 0;
    @(posedge clk); #1;
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL abort_err got=%b exp=1", err3); end
    checks++; if (wait3 !== 1'b0) begin errors++; $display("FAIL abort_idle_wait got=%b exp=0", wait3); end
    checks++; if (rdata3 !== 32'h01020304) begin errors++; $display("FAIL abort_rdata got=%h exp=01020304", rdata3); end
    rd = 1;
    highs = 0;
    @(negedge clk);
    while (wait3 && highs < 20) begin
      highs++;
      @(negedge clk);
    end
    checks++; if (highs != 3) begin errors++; $display("FAIL abort_restart_wait got=%0d exp=3", highs); end
    @(posedge clk); #1;
    rd = 0;
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    sel = 1; wr = 1; rd = 0; address = 32'hBFC00010; wdata = 32'h55667788; be = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (wait3 !== 1'b1) begin errors++; $display("FAIL rst_wait_high got=%b exp=1", wait3); end
    @(posedge clk); #1;
    reset = 1'b0; wr = 0;
    @(negedge clk);
    checks++; if (wait3 !== 1'b0) begin errors++; $display("FAIL rst_wait_low got=%b exp=0", wait3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata3); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err3); end
    dbg_index = 32'd4;
    #1;
    checks++; if (dbg3 !== 32'h04030201) begin errors++; $display("FAIL rst_mem got=%h exp=04030201", dbg3); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    apply_reset();
    test_rw_both();
    test_wait_states();
    test_abort();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
